// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: fetch FSM encoding,
// decoder path indices and MIPS opcode/funct constants.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_EXEC  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Decoder path_index values
    localparam logic [3:0] PATH_R      = 4'b0001;
    localparam logic [3:0] PATH_LW     = 4'b0010;
    localparam logic [3:0] PATH_SW     = 4'b0011;
    localparam logic [3:0] PATH_BEQ    = 4'b0100;
    localparam logic [3:0] PATH_J      = 4'b0101;
    localparam logic [3:0] PATH_JAL    = 4'b0110;
    localparam logic [3:0] PATH_MULDIV = 4'b0111;
    localparam logic [3:0] PATH_JR     = 4'b1000;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;

    // True when an address may be used as an instruction fetch address
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC resolution: jr, then j/jal, then taken beq,
// otherwise sequential flow. Also flags a misaligned jr target.
module next_pc_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [25:0] jump_address,
    input  logic [31:0] imm_extended,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] w_branch_offset;

    // Priority-ordered target selection; all arithmetic wraps at 32 bits
    always_comb begin
        pc_plus4        = pc + LINK_OFFSET;
        w_branch_offset = imm_extended << 2;
        next_pc         = pc_plus4;
        misalign        = 1'b0;
        if (jump_reg) begin
            next_pc  = {rs_data[31:2], 2'b00};
            misalign = !is_word_aligned(rs_data);
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_address, 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + w_branch_offset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, pulses instr_valid to the decoder, then waits for the
// downstream retire pulse before resolving the next PC.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_update,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [25:0] jump_address,
    input  logic [31:0] imm_extended,
    input  logic [31:0] rs_data,
    output logic        addr_err,
    output logic [31:0] retired_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         w_imem_req;
    logic         w_instr_valid;
    logic         w_fetch_done;
    logic         w_retire;

    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_addr_err;
    logic [31:0]  r_retired_count;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_misalign;

    next_pc_calc #(
        .LINK_OFFSET (LINK_OFFSET)
    ) u_next_pc_calc (
        .pc           (r_pc),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .jump_address (jump_address),
        .imm_extended (imm_extended),
        .rs_data      (rs_data),
        .pc_plus4     (w_pc_plus4),
        .next_pc      (w_next_pc),
        .misalign     (w_misalign)
    );

    // FSM state register; reset drops imem_req immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; en only matters when starting a fetch
    always_comb begin
        w_state_next  = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_fetch_done  = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_instr_valid = 1'b1;
                w_state_next  = ST_EXEC;
            end
            ST_EXEC: begin
                if (pc_update) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: latch fetched word, advance PC and count on retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_instr         <= NOP_INSTR;
            r_addr_err      <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            if (w_fetch_done) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc            <= w_next_pc;
                r_retired_count <= r_retired_count + 32'd1;
                if (w_misalign) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    // The PC only moves in EXEC, so the fetch address is stable throughout REQ
    assign imem_req      = w_imem_req;
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = w_instr_valid;
    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign addr_err      = r_addr_err;
    assign retired_count = r_retired_count;

endmodule
